// File: rtl/aud_play_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : aud_play_ctrl                                                 |
// | Purpose  : Playback sequencer for the audio PWM datapath. Fetches        |
// |            samples from sample memory (req/gnt/rvalid), buffers them in  |
// |            a 2-entry prefetch FIFO and presents one duty value per       |
// |            programmable sample period, with loop, start/stop control and |
// |            done/underrun status.                                         |
// | Ports    : clk, rst_n              - clock, async active-low reset       |
// |            cfg_start_addr, cfg_len - clip location and length (samples)  |
// |            cfg_div, cfg_loop       - period = cfg_div+1, loop enable     |
// |            start, stop             - single-cycle control pulses         |
// |            mem_req/addr/gnt        - read request handshake              |
// |            mem_rvalid/rdata        - read response                       |
// |            duty_o, duty_tick       - duty value and its update strobe    |
// |            busy, done, underrun    - status                              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module aud_play_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 18,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] cfg_start_addr,
   input  logic [ADDR_WIDTH-1:0] cfg_len,
   input  logic [DIV_WIDTH-1:0]  cfg_div,
   input  logic                  cfg_loop,
   input  logic                  start,
   input  logic                  stop,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [DATA_WIDTH-1:0] duty_o,
   output logic                  duty_tick,
   output logic                  busy,
   output logic                  done,
   output logic                  underrun
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PREFILL = 2'd1,
      ST_PLAY    = 2'd2,
      ST_ABORT   = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] c_addr_one = ADDR_WIDTH'(1);
   localparam logic [DIV_WIDTH-1:0]  c_div_one  = DIV_WIDTH'(1);

   state_t                r_state;
   state_t                w_state_nxt;

   // Shadow configuration, captured when start is accepted
   logic [ADDR_WIDTH-1:0] r_start_addr;
   logic [ADDR_WIDTH-1:0] r_len;
   logic [DIV_WIDTH-1:0]  r_div;
   logic                  r_loop;

   // Fetch engine
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH-1:0] r_fetch_rem;
   logic                  r_out;       // granted, awaiting rvalid
   logic                  r_pend;      // in ABORT: request still awaiting gnt

   // Prefetch FIFO
   logic [DATA_WIDTH-1:0] r_fifo [2];
   logic                  r_rptr;
   logic                  r_wptr;
   logic [1:0]            r_count;

   // Playback
   logic [ADDR_WIDTH-1:0] r_play_rem;  // samples left including the one on duty_o
   logic [DIV_WIDTH-1:0]  r_cnt;
   logic [DATA_WIDTH-1:0] r_duty;
   logic                  r_tick;
   logic                  r_done;
   logic                  r_underrun;

   logic                  w_fetching;
   logic                  w_fetch_req;
   logic                  w_gnt_acc;
   logic                  w_push;
   logic                  w_avail;
   logic [DATA_WIDTH-1:0] w_head;
   logic                  w_out_nxt;
   logic                  w_pend_nxt;
   logic                  w_pop;
   logic                  w_take;
   logic                  w_store;
   logic                  w_flush;
   logic                  w_load;
   logic                  w_tick_nxt;
   logic                  w_done_nxt;
   logic [DATA_WIDTH-1:0] w_duty_nxt;
   logic [DIV_WIDTH-1:0]  w_cnt_nxt;
   logic [ADDR_WIDTH-1:0] w_play_rem_nxt;
   logic                  w_underrun_nxt;

   assign w_fetching  = (r_state == ST_PREFILL) || (r_state == ST_PLAY);
   // Occupancy + outstanding < 2, with at most one request in flight
   assign w_fetch_req = w_fetching && !r_out && (r_count < 2'd2) && (r_fetch_rem != '0);
   assign mem_req     = w_fetch_req || ((r_state == ST_ABORT) && r_pend);
   assign mem_addr    = r_addr;
   assign w_gnt_acc   = mem_req && mem_gnt;
   assign w_out_nxt   = (r_out && !mem_rvalid) || w_gnt_acc;

   // Response data lands in the FIFO; when the FIFO is empty a pop in the
   // same cycle takes the arriving word directly so no cycle is lost.
   assign w_push  = w_fetching && r_out && mem_rvalid;
   assign w_avail = (r_count != 2'd0) || w_push;
   assign w_head  = (r_count != 2'd0) ? r_fifo[r_rptr] : mem_rdata;
   assign w_take  = w_pop && (r_count != 2'd0);
   assign w_store = w_push && !(w_pop && (r_count == 2'd0));

   assign duty_o    = r_duty;
   assign duty_tick = r_tick;
   assign busy      = (r_state != ST_IDLE);
   assign done      = r_done;
   assign underrun  = r_underrun;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_pend_nxt     = 1'b0;
      w_pop          = 1'b0;
      w_flush        = 1'b0;
      w_load         = 1'b0;
      w_tick_nxt     = 1'b0;
      w_done_nxt     = 1'b0;
      w_duty_nxt     = r_duty;
      w_cnt_nxt      = r_cnt;
      w_play_rem_nxt = r_play_rem;
      w_underrun_nxt = r_underrun;
      case (r_state)
         ST_IDLE: begin
            if (start && !stop) begin
               w_underrun_nxt = 1'b0;
               if (cfg_len == '0) begin
                  w_done_nxt = 1'b1;
               end else begin
                  w_load         = 1'b1;
                  w_play_rem_nxt = cfg_len;
                  w_state_nxt    = ST_PREFILL;
               end
            end
         end
         ST_PREFILL, ST_PLAY: begin
            if (stop) begin
               w_flush     = 1'b1;
               w_duty_nxt  = '0;
               w_pend_nxt  = mem_req && !mem_gnt;
               w_state_nxt = (w_out_nxt || w_pend_nxt) ? ST_ABORT : ST_IDLE;
            end else if (r_state == ST_PREFILL) begin
               // First sample goes out as soon as it arrives; it does not
               // consume play_remaining, which counts the sample on duty_o.
               if (w_avail) begin
                  w_pop       = 1'b1;
                  w_duty_nxt  = w_head;
                  w_tick_nxt  = 1'b1;
                  w_cnt_nxt   = r_div;
                  w_state_nxt = ST_PLAY;
               end
            end else if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - c_div_one;
            end else if ((r_play_rem == c_addr_one) && !r_loop) begin
               w_done_nxt  = 1'b1;
               w_duty_nxt  = '0;
               w_flush     = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (w_avail) begin
               w_pop          = 1'b1;
               w_duty_nxt     = w_head;
               w_tick_nxt     = 1'b1;
               w_cnt_nxt      = r_div;
               w_play_rem_nxt = (r_play_rem == c_addr_one) ? r_len : (r_play_rem - c_addr_one);
            end else begin
               // Counter parks at 0 so the pop is retried every cycle
               w_underrun_nxt = 1'b1;
            end
         end
         ST_ABORT: begin
            w_pend_nxt = r_pend && !mem_gnt;
            if (!w_pend_nxt && !w_out_nxt) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_start_addr <= '0;
         r_len        <= '0;
         r_div        <= '0;
         r_loop       <= 1'b0;
         r_addr       <= '0;
         r_fetch_rem  <= '0;
         r_out        <= 1'b0;
         r_pend       <= 1'b0;
         r_fifo[0]    <= '0;
         r_fifo[1]    <= '0;
         r_rptr       <= 1'b0;
         r_wptr       <= 1'b0;
         r_count      <= 2'd0;
         r_play_rem   <= '0;
         r_cnt        <= '0;
         r_duty       <= '0;
         r_tick       <= 1'b0;
         r_done       <= 1'b0;
         r_underrun   <= 1'b0;
      end else begin
         r_out      <= w_out_nxt;
         r_pend     <= w_pend_nxt;
         r_play_rem <= w_play_rem_nxt;
         r_cnt      <= w_cnt_nxt;
         r_duty     <= w_duty_nxt;
         r_tick     <= w_tick_nxt;
         r_done     <= w_done_nxt;
         r_underrun <= w_underrun_nxt;

         if (w_load) begin
            r_start_addr <= cfg_start_addr;
            r_len        <= cfg_len;
            r_div        <= cfg_div;
            r_loop       <= cfg_loop;
            r_addr       <= cfg_start_addr;
            r_fetch_rem  <= cfg_len;
         end else if (w_fetch_req && mem_gnt) begin
            if ((r_fetch_rem == c_addr_one) && r_loop) begin
               r_addr      <= r_start_addr;
               r_fetch_rem <= r_len;
            end else begin
               r_addr      <= r_addr + c_addr_one;
               r_fetch_rem <= r_fetch_rem - c_addr_one;
            end
         end

         if (w_flush) begin
            r_rptr  <= 1'b0;
            r_wptr  <= 1'b0;
            r_count <= 2'd0;
         end else begin
            if (w_store) begin
               r_fifo[r_wptr] <= mem_rdata;
               r_wptr         <= ~r_wptr;
            end
            if (w_take) begin
               r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_store} - {1'b0, w_take};
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_aud_play_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_aud_play_ctrl                                              |
// | Purpose  : Self-checking bench for aud_play_ctrl with a sample-memory    |
// |            model returning addr[7:0] as data, programmable gnt hold-off  |
// |            and rvalid latency.                                           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_aud_play_ctrl;

   localparam int DW = 8;
   localparam int AW = 18;
   localparam int VW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] cfg_start_addr;
   logic [AW-1:0] cfg_len;
   logic [VW-1:0] cfg_div;
   logic          cfg_loop;
   logic          start;
   logic          stop;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_gnt;
   logic          mem_rvalid;
   logic [DW-1:0] mem_rdata;
   logic [DW-1:0] duty_o;
   logic          duty_tick;
   logic          busy;
   logic          done;
   logic          underrun;

   int            gnt_hold;
   int            rv_dly;
   int            wait_cnt;
   logic          rv_pend;
   int            rv_cnt;
   logic [7:0]    rv_data;

   int            checks = 0;
   int            errors = 0;
   logic          saw_done;

   typedef struct {
      logic       st;
      logic       sp;
      logic       busy;
      logic       req;
      logic       tick;
      logic [7:0] duty;
      logic       done;
   } vec_t;

   vec_t vecs [20];

   aud_play_ctrl #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .DIV_WIDTH (VW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_start_addr(cfg_start_addr),
      .cfg_len       (cfg_len),
      .cfg_div       (cfg_div),
      .cfg_loop      (cfg_loop),
      .start         (start),
      .stop          (stop),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_gnt       (mem_gnt),
      .mem_rvalid    (mem_rvalid),
      .mem_rdata     (mem_rdata),
      .duty_o        (duty_o),
      .duty_tick     (duty_tick),
      .busy          (busy),
      .done          (done),
      .underrun      (underrun)
   );

   always #5 clk = ~clk;

   // Memory model: gnt after gnt_hold waiting cycles, rvalid rv_dly cycles after gnt
   assign mem_gnt = mem_req && (wait_cnt >= gnt_hold);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_rvalid <= 1'b0;
         mem_rdata  <= '0;
         rv_pend    <= 1'b0;
         rv_cnt     <= 0;
         rv_data    <= '0;
         wait_cnt   <= 0;
      end else begin
         mem_rvalid <= 1'b0;
         if (rv_pend) begin
            if (rv_cnt <= 1) begin
               mem_rvalid <= 1'b1;
               mem_rdata  <= rv_data;
               rv_pend    <= 1'b0;
            end else begin
               rv_cnt <= rv_cnt - 1;
            end
         end
         if (mem_req && mem_gnt) begin
            wait_cnt <= 0;
            if (rv_dly <= 1) begin
               mem_rvalid <= 1'b1;
               mem_rdata  <= mem_addr[7:0];
            end else begin
               rv_pend <= 1'b1;
               rv_cnt  <= rv_dly - 1;
               rv_data <= mem_addr[7:0];
            end
         end else if (mem_req) begin
            wait_cnt <= wait_cnt + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int max);
      int n;
      n = 0;
      while (busy && n < max) begin
         if (done) saw_done = 1'b1;
         step();
         n++;
      end
      if (done) saw_done = 1'b1;
      chk("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   task automatic set_cfg(input logic [AW-1:0] a, input logic [AW-1:0] l,
                          input logic [VW-1:0] d, input logic lp);
      cfg_start_addr = a;
      cfg_len        = l;
      cfg_div        = d;
      cfg_loop       = lp;
   endtask

   function automatic vec_t mk(input logic st, input logic sp, input logic b, input logic r,
                               input logic t, input logic [7:0] d, input logic dn);
      vec_t v;
      v.st = st; v.sp = sp; v.busy = b; v.req = r; v.tick = t; v.duty = d; v.done = dn;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
      set_cfg('0, '0, '0, 1'b0);
      gnt_hold = 0;
      rv_dly   = 1;
      saw_done = 1'b0;

      // Basic clip: addr 0x10, len 3, div 4; start again at cycle 9 is ignored
      vecs[0]  = mk(1, 0, 0, 0, 0, 8'h00, 0);
      vecs[1]  = mk(0, 0, 1, 1, 0, 8'h00, 0);
      vecs[2]  = mk(0, 0, 1, 0, 0, 8'h00, 0);
      vecs[3]  = mk(0, 0, 1, 1, 1, 8'h10, 0);
      vecs[4]  = mk(0, 0, 1, 0, 0, 8'h10, 0);
      vecs[5]  = mk(0, 0, 1, 1, 0, 8'h10, 0);
      vecs[6]  = mk(0, 0, 1, 0, 0, 8'h10, 0);
      vecs[7]  = mk(0, 0, 1, 0, 0, 8'h10, 0);
      vecs[8]  = mk(0, 0, 1, 0, 1, 8'h11, 0);
      for (int i = 9; i <= 12; i++) vecs[i] = mk(0, 0, 1, 0, 0, 8'h11, 0);
      vecs[9]  = mk(1, 0, 1, 0, 0, 8'h11, 0);
      vecs[13] = mk(0, 0, 1, 0, 1, 8'h12, 0);
      for (int i = 14; i <= 17; i++) vecs[i] = mk(0, 0, 1, 0, 0, 8'h12, 0);
      vecs[18] = mk(0, 0, 0, 0, 0, 8'h00, 1);
      vecs[19] = mk(0, 0, 0, 0, 0, 8'h00, 0);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_req", {31'd0, mem_req}, 0);
      chk("rst_addr", {14'd0, mem_addr}, 0);
      chk("rst_duty", {24'd0, duty_o}, 0);
      chk("rst_tick", {31'd0, duty_tick}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_underrun", {31'd0, underrun}, 0);
      rst_n = 1'b1;
      step();

      // ---------------- table-driven basic clip ----------------
      set_cfg(18'h10, 18'd3, 16'd4, 1'b0);
      for (int i = 0; i < 20; i++) begin
         start = vecs[i].st;
         stop  = vecs[i].sp;
         chk($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
         chk($sformatf("tbl%0d_req", i), {31'd0, mem_req}, {31'd0, vecs[i].req});
         chk($sformatf("tbl%0d_tick", i), {31'd0, duty_tick}, {31'd0, vecs[i].tick});
         chk($sformatf("tbl%0d_duty", i), {24'd0, duty_o}, {24'd0, vecs[i].duty});
         chk($sformatf("tbl%0d_done", i), {31'd0, done}, {31'd0, vecs[i].done});
         chk($sformatf("tbl%0d_underrun", i), {31'd0, underrun}, 0);
         if (i == 1) chk("tbl_addr_first", {14'd0, mem_addr}, 32'h10);
         step();
      end
      start = 1'b0;

      // ---------------- loop wrap ----------------
      begin
         int   ntick;
         logic bad_addr;
         ntick    = 0;
         bad_addr = 1'b0;
         saw_done = 1'b0;
         set_cfg(18'h10, 18'd2, 16'd3, 1'b1);
         for (int c = 0; c <= 40; c++) begin
            start = (c == 0);
            if (c > 0) begin
               if (duty_tick) begin
                  chk("loop_duty", {24'd0, duty_o}, 32'h10 + (ntick % 2));
                  chk("loop_spacing", (c - 3) % 4, 0);
                  ntick++;
               end
               if (mem_req && mem_addr == 18'h12) bad_addr = 1'b1;
               if (done) saw_done = 1'b1;
            end
            step();
         end
         start = 1'b0;
         chk("loop_ticks", ntick, 10);
         chk("loop_addr_0x12", {31'd0, bad_addr}, 0);
         stop = 1'b1;
         step();
         stop = 1'b0;
         wait_idle(10);
         chk("loop_stop_duty", {24'd0, duty_o}, 0);
         chk("loop_no_done", {31'd0, saw_done}, 0);
         step();
      end

      // ---------------- underrun ----------------
      rv_dly = 4;
      set_cfg(18'h10, 18'd3, 16'd1, 1'b0);
      for (int c = 0; c <= 18; c++) begin
         start = (c == 0);
         case (c)
            6:  begin chk("ur_tick6", {31'd0, duty_tick}, 1); chk("ur_duty6", {24'd0, duty_o}, 32'h10); end
            7:  chk("ur_flag7", {31'd0, underrun}, 0);
            8:  begin chk("ur_flag8", {31'd0, underrun}, 1); chk("ur_tick8", {31'd0, duty_tick}, 0); end
            9:  begin chk("ur_hold9", {24'd0, duty_o}, 32'h10); chk("ur_tick9", {31'd0, duty_tick}, 0); end
            11: begin chk("ur_tick11", {31'd0, duty_tick}, 1); chk("ur_duty11", {24'd0, duty_o}, 32'h11); end
            16: begin chk("ur_tick16", {31'd0, duty_tick}, 1); chk("ur_duty16", {24'd0, duty_o}, 32'h12); end
            18: begin
               chk("ur_done18", {31'd0, done}, 1);
               chk("ur_busy18", {31'd0, busy}, 0);
               chk("ur_sticky18", {31'd0, underrun}, 1);
            end
            default: ;
         endcase
         step();
      end
      rv_dly = 1;
      set_cfg(18'h20, 18'd1, 16'd2, 1'b0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("ur_cleared", {31'd0, underrun}, 0);
      chk("ur_restart_busy", {31'd0, busy}, 1);
      wait_idle(20);
      step();

      // ---------------- abort with withheld gnt ----------------
      gnt_hold = 3;
      saw_done = 1'b0;
      set_cfg(18'h10, 18'd3, 16'd4, 1'b0);
      for (int c = 0; c <= 8; c++) begin
         start = (c == 0);
         stop  = (c == 2);
         if (done) saw_done = 1'b1;
         case (c)
            2: chk("ab_req2", {31'd0, mem_req}, 1);
            3: begin
               chk("ab_req3", {31'd0, mem_req}, 1);
               chk("ab_addr3", {14'd0, mem_addr}, 32'h10);
               chk("ab_busy3", {31'd0, busy}, 1);
               chk("ab_duty3", {24'd0, duty_o}, 0);
            end
            4: begin
               chk("ab_req4", {31'd0, mem_req}, 1);
               chk("ab_addr4", {14'd0, mem_addr}, 32'h10);
            end
            5: begin chk("ab_req5", {31'd0, mem_req}, 0); chk("ab_busy5", {31'd0, busy}, 1); end
            6: begin chk("ab_busy6", {31'd0, busy}, 0); chk("ab_duty6", {24'd0, duty_o}, 0); end
            default: ;
         endcase
         step();
      end
      stop = 1'b0;
      chk("ab_no_done", {31'd0, saw_done}, 0);
      gnt_hold = 0;

      // ---------------- stop with nothing outstanding ----------------
      set_cfg(18'h10, 18'd3, 16'd4, 1'b0);
      for (int c = 0; c <= 9; c++) begin
         start = (c == 0);
         stop  = (c == 7);
         if (c == 8) begin
            chk("st_busy8", {31'd0, busy}, 0);
            chk("st_duty8", {24'd0, duty_o}, 0);
            chk("st_req8", {31'd0, mem_req}, 0);
         end
         if (c >= 8) chk("st_no_done", {31'd0, done}, 0);
         step();
      end
      stop = 1'b0;

      // ---------------- len = 0 ----------------
      set_cfg(18'h10, 18'd0, 16'd4, 1'b0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("len0_done", {31'd0, done}, 1);
      chk("len0_busy", {31'd0, busy}, 0);
      chk("len0_req", {31'd0, mem_req}, 0);
      step();
      chk("len0_done_pulse", {31'd0, done}, 0);

      // ---------------- start and stop together ----------------
      set_cfg(18'h10, 18'd3, 16'd4, 1'b0);
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      chk("ss_busy1", {31'd0, busy}, 0);
      chk("ss_req1", {31'd0, mem_req}, 0);
      step();
      chk("ss_busy2", {31'd0, busy}, 0);

      // ---------------- address wrap ----------------
      set_cfg(18'h3FFFF, 18'd2, 16'd2, 1'b0);
      for (int c = 0; c <= 3; c++) begin
         start = (c == 0);
         if (c == 1) begin
            chk("wr_req1", {31'd0, mem_req}, 1);
            chk("wr_addr1", {14'd0, mem_addr}, 32'h3FFFF);
         end
         if (c == 3) begin
            chk("wr_tick3", {31'd0, duty_tick}, 1);
            chk("wr_duty3", {24'd0, duty_o}, 32'hFF);
            chk("wr_req3", {31'd0, mem_req}, 1);
            chk("wr_addr3", {14'd0, mem_addr}, 0);
         end
         step();
      end
      start = 1'b0;
      wait_idle(20);
      step();

      // ---------------- reset mid-PLAY ----------------
      rv_dly = 4;
      set_cfg(18'h10, 18'd3, 16'd1, 1'b0);
      for (int c = 0; c < 9; c++) begin
         start = (c == 0);
         step();
      end
      start = 1'b0;
      chk("mr_pre_underrun", {31'd0, underrun}, 1);
      rst_n = 1'b0;
      #1;
      chk("mr_busy", {31'd0, busy}, 0);
      chk("mr_req", {31'd0, mem_req}, 0);
      chk("mr_addr", {14'd0, mem_addr}, 0);
      chk("mr_duty", {24'd0, duty_o}, 0);
      chk("mr_tick", {31'd0, duty_tick}, 0);
      chk("mr_done", {31'd0, done}, 0);
      chk("mr_underrun", {31'd0, underrun}, 0);
      step();
      step();
      rst_n  = 1'b1;
      rv_dly = 1;
      step();
      set_cfg(18'h10, 18'd3, 16'd4, 1'b0);
      for (int c = 0; c <= 4; c++) begin
         start = (c == 0);
         if (c == 1) begin
            chk("pr_busy1", {31'd0, busy}, 1);
            chk("pr_req1", {31'd0, mem_req}, 1);
            chk("pr_addr1", {14'd0, mem_addr}, 32'h10);
         end
         if (c == 3) begin
            chk("pr_tick3", {31'd0, duty_tick}, 1);
            chk("pr_duty3", {24'd0, duty_o}, 32'h10);
         end
         if (c == 4) chk("pr_duty4", {24'd0, duty_o}, 32'h10);
         step();
      end
      start = 1'b0;
      wait_idle(30);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
